// File: rtl/bram_port_master_if.sv
// Request/response channel plus RAM port pins of bram_port_master.
// master = the front-end block's view, slave = client logic and RAM side.
interface bram_port_master_if #(
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 9
);
    localparam int W = NB_COL * COL_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic [NB_COL-1:0]     req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [W-1:0]          req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W-1:0]          rsp_rdata;
    logic                  idle;
    logic                  bram_en;
    logic [NB_COL-1:0]     bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [W-1:0]          bram_din;
    logic                  bram_regce;
    logic                  bram_rst;
    logic [W-1:0]          bram_dout;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, bram_dout,
        output req_ready, rsp_valid, rsp_rdata, idle,
               bram_en, bram_we, bram_addr, bram_din, bram_regce, bram_rst
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, bram_dout,
        input  req_ready, rsp_valid, rsp_rdata, idle,
               bram_en, bram_we, bram_addr, bram_din, bram_regce, bram_rst
    );
endinterface

// File: rtl/bram_port_master.sv
// Drives one byte-enable BRAM port from a valid/ready request channel, returns read data in order.
// Read latency READ_LATENCY+1 to rsp_valid; reads are credit-gated so a stalled consumer never drops data.
module bram_port_master #(
    parameter int NB_COL       = 4,
    parameter int COL_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    bram_port_master_if.master  bus
);
    localparam int W  = NB_COL * COL_WIDTH;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);

    logic                    req_ready_q;
    logic [CW-1:0]           credits;
    logic [CW-1:0]           credits_nxt;
    logic [READ_LATENCY-1:0] tok;
    logic [W-1:0]            fifo_mem [RESP_DEPTH];
    logic [PW:0]             wr_ptr;
    logic [PW:0]             rd_ptr;
    logic                    fire;
    logic                    rd_fire;
    logic                    fifo_empty;
    logic                    pop;
    logic                    push;

    assign fire       = bus.req_valid & bus.req_ready;
    assign rd_fire    = fire & ~(|bus.req_we);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign pop        = ~fifo_empty & bus.rsp_ready;
    assign push       = tok[READ_LATENCY-1];

    // RAM port is a pure function of the accepted request
    assign bus.bram_en    = fire;
    assign bus.bram_we    = bus.req_we & {NB_COL{fire}};
    assign bus.bram_addr  = bus.req_addr;
    assign bus.bram_din   = bus.req_wdata;
    assign bus.bram_regce = (READ_LATENCY == 2) ? tok[0] : 1'b0;
    assign bus.bram_rst   = 1'b0;

    assign bus.req_ready = req_ready_q & ~rst;
    assign bus.rsp_valid = ~fifo_empty;
    assign bus.rsp_rdata = fifo_empty ? '0 : fifo_mem[rd_ptr[PW-1:0]];
    assign bus.idle      = (credits == CW'(RESP_DEPTH));

    // Writes need a credit to pass the ready gate but only reads consume one
    always_comb begin
        credits_nxt = credits;
        case ({rd_fire, pop})
            2'b10:   credits_nxt = credits - 1'b1;
            2'b01:   credits_nxt = credits + 1'b1;
            default: credits_nxt = credits;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits     <= CW'(RESP_DEPTH);
            req_ready_q <= 1'b1;
            tok         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            credits     <= credits_nxt;
            req_ready_q <= (credits_nxt != '0);
            tok         <= (tok << 1) | READ_LATENCY'(rd_fire);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= bus.bram_dout;
    end
endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: behavioural RAMs on two instances (latency 2 and 1),
// scoreboard of expected read data computed from an abstract memory image at accept time.
module tb_bram_port_master;
    logic clk;
    logic rst;
    int   npass;
    int   ntot;
    int   cyc;
    int   outst;

    bram_port_master_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(9)) if2 ();
    bram_port_master_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(9)) if1 ();

    bram_port_master #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(9), .READ_LATENCY(2), .RESP_DEPTH(4))
        dut2 (.clk(clk), .rst(rst), .bus(if2));
    bram_port_master #(.NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(9), .READ_LATENCY(1), .RESP_DEPTH(4))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM ports: read-first, optional output register
    logic [31:0] ram2 [512];
    logic [31:0] lat2, oreg2;
    logic [31:0] ram1 [512];
    logic [31:0] lat1;

    always @(posedge clk) begin
        if (if2.bram_en) begin
            lat2 <= ram2[if2.bram_addr];
            for (int b = 0; b < 4; b++)
                if (if2.bram_we[b]) ram2[if2.bram_addr][b*8 +: 8] <= if2.bram_din[b*8 +: 8];
        end
        if (if2.bram_rst) oreg2 <= '0;
        else if (if2.bram_regce) oreg2 <= lat2;
    end
    assign if2.bram_dout = oreg2;

    always @(posedge clk) begin
        if (if1.bram_en) begin
            lat1 <= ram1[if1.bram_addr];
            for (int b = 0; b < 4; b++)
                if (if1.bram_we[b]) ram1[if1.bram_addr][b*8 +: 8] <= if1.bram_din[b*8 +: 8];
        end
    end
    assign if1.bram_dout = lat1;

    // Reference model: memory image plus queues of expected / observed responses
    logic [31:0] model_mem [512];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          acc_cyc [$];
    int          pop_cyc [$];
    int          n_rd;

    always @(posedge clk)
        if (!rst && outst > 4) $error("FAIL fifo_overflow outstanding=%0d limit=4", outst);

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); pop_cyc.delete();
        n_rd = 0;
    endtask

    // One clock cycle on dut2: record accepts and pops, update model, advance.
    task automatic step();
        bit f, p;
        f = if2.req_valid && if2.req_ready;
        p = if2.rsp_valid && if2.rsp_ready;
        if (p) begin
            got_q.push_back(if2.rsp_rdata);
            pop_cyc.push_back(cyc);
            outst--;
        end
        if (f) begin
            if (if2.req_we == 4'b0) begin
                exp_q.push_back(model_mem[if2.req_addr]);
                acc_cyc.push_back(cyc);
                n_rd++;
                outst++;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (if2.req_we[b]) model_mem[if2.req_addr][b*8 +: 8] = if2.req_wdata[b*8 +: 8];
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [3:0] we, input int addr, input logic [31:0] d);
        if2.req_valid = v;
        if2.req_we    = we;
        if2.req_addr  = 9'(addr);
        if2.req_wdata = d;
    endtask

    task automatic test_reset();
        ntot++; if (if2.req_ready !== 1'b0) $display("FAIL rst_req_ready got=%b exp=0", if2.req_ready); else npass++;
        ntot++; if (if2.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", if2.rsp_valid); else npass++;
        ntot++; if (if2.rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got=%h exp=0", if2.rsp_rdata); else npass++;
        ntot++; if (if2.idle !== 1'b1) $display("FAIL rst_idle got=%b exp=1", if2.idle); else npass++;
        ntot++; if (if2.bram_regce !== 1'b0 || if2.bram_rst !== 1'b0)
            $display("FAIL rst_regce_rst got=%b%b exp=00", if2.bram_regce, if2.bram_rst); else npass++;
        rst = 1'b0;
        #1;
        ntot++; if (if2.req_ready !== 1'b1) $display("FAIL rel_req_ready got=%b exp=1", if2.req_ready); else npass++;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        clear_sb();
        if2.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'hF, i, 32'h1000_0000 + 32'(i));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'h0, i, 32'h0);
            ntot++; if (if2.req_ready !== 1'b1) $display("FAIL stream_ready i=%0d got=%b exp=1", i, if2.req_ready); else npass++;
            step();
        end
        drive(1'b0, 4'h0, 0, 32'h0);
        for (int t = 0; t < 40 && got_q.size() < 8; t++) step();
        ntot++; if (got_q.size() != 8) $display("FAIL stream_count got=%0d exp=8", got_q.size()); else npass++;
        if (got_q.size() == 8) begin
            ntot++; if (pop_cyc[0] - acc_cyc[0] != 3)
                $display("FAIL stream_latency got=%0d exp=3", pop_cyc[0] - acc_cyc[0]); else npass++;
            for (int i = 0; i < 8; i++) begin
                ntot++; if (got_q[i] !== 32'h1000_0000 + 32'(i) || got_q[i] !== exp_q[i])
                    $display("FAIL stream_data i=%0d got=%h exp=%h", i, got_q[i], 32'h1000_0000 + 32'(i)); else npass++;
                ntot++; if (pop_cyc[i] != pop_cyc[0] + i)
                    $display("FAIL stream_rate i=%0d got=%0d exp=%0d", i, pop_cyc[i], pop_cyc[0] + i); else npass++;
            end
        end
    endtask

    task automatic test_byte_enable();
        clear_sb();
        if2.rsp_ready = 1'b1;
        drive(1'b1, 4'hF, 5, 32'hAABB_CCDD); step();
        drive(1'b1, 4'b0010, 5, 32'h1122_3344); step();
        drive(1'b1, 4'h0, 5, 32'h0); step();
        drive(1'b0, 4'h0, 0, 32'h0);
        for (int t = 0; t < 20 && got_q.size() < 1; t++) step();
        ntot++; if (got_q.size() != 1) $display("FAIL be_count got=%0d exp=1", got_q.size());
        else if (got_q[0] !== 32'hAABB_33DD || got_q[0] !== exp_q[0])
            $display("FAIL be_data got=%h exp=AABB33DD", got_q[0]);
        else npass++;
    endtask

    task automatic test_backpressure();
        clear_sb();
        if2.rsp_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            drive(1'b1, 4'h0, n_rd, 32'h0);
            if (n_rd == 4) begin
                ntot++; if (if2.req_ready !== 1'b0) $display("FAIL bp_ready_low t=%0d got=%b exp=0", t, if2.req_ready); else npass++;
            end
            step();
        end
        ntot++; if (n_rd != 4) $display("FAIL bp_accepted got=%0d exp=4", n_rd); else npass++;
        if2.rsp_ready = 1'b1;
        for (int t = 0; t < 60 && (got_q.size() < 6 || n_rd < 6); t++) begin
            if (n_rd < 6) drive(1'b1, 4'h0, n_rd, 32'h0);
            else drive(1'b0, 4'h0, 0, 32'h0);
            step();
        end
        drive(1'b0, 4'h0, 0, 32'h0);
        ntot++; if (got_q.size() != 6) $display("FAIL bp_count got=%0d exp=6", got_q.size()); else npass++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            ntot++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_data i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else npass++;
        end
        ntot++; if (if2.idle !== 1'b1) $display("FAIL bp_idle got=%b exp=1", if2.idle); else npass++;
    endtask

    task automatic test_collision();
        clear_sb();
        if2.rsp_ready = 1'b1;
        drive(1'b1, 4'hF, 3, 32'h55); step();
        drive(1'b1, 4'h0, 3, 32'h0);  step();
        drive(1'b1, 4'hF, 3, 32'h66); step();
        drive(1'b1, 4'h0, 3, 32'h0);  step();
        drive(1'b0, 4'h0, 0, 32'h0);
        for (int t = 0; t < 20 && got_q.size() < 2; t++) step();
        ntot++; if (got_q.size() != 2) $display("FAIL col_count got=%0d exp=2", got_q.size());
        else if (got_q[0] !== 32'h55 || got_q[0] !== exp_q[0]) $display("FAIL col_first got=%h exp=55", got_q[0]);
        else npass++;
        ntot++; if (got_q.size() == 2 && got_q[1] !== 32'h66) $display("FAIL col_second got=%h exp=66", got_q[1]);
        else if (got_q.size() == 2) npass++;
        else $display("FAIL col_second got=none exp=66");
    endtask

    task automatic test_random();
        bit pv, pr;
        logic [31:0] pd;
        clear_sb();
        if2.rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'hF, a, $urandom); step();
        end
        for (int t = 0; t < 300; t++) begin
            drive(($urandom % 4) != 0, ($urandom % 2) ? 4'h0 : 4'($urandom), int'($urandom % 16), $urandom);
            if2.rsp_ready = ($urandom % 3) != 0;
            ntot++; if (if2.req_ready !== (outst < 4) || if2.idle !== (outst == 0))
                $display("FAIL rnd_flags t=%0d ready=%b idle=%b outstanding=%0d", t, if2.req_ready, if2.idle, outst); else npass++;
            pv = if2.rsp_valid; pr = if2.rsp_ready; pd = if2.rsp_rdata;
            step();
            if (pv && !pr) begin
                ntot++; if (if2.rsp_valid !== 1'b1 || if2.rsp_rdata !== pd)
                    $display("FAIL rnd_hold t=%0d got=%b/%h exp=1/%h", t, if2.rsp_valid, if2.rsp_rdata, pd); else npass++;
            end
        end
        drive(1'b0, 4'h0, 0, 32'h0);
        if2.rsp_ready = 1'b1;
        for (int t = 0; t < 40 && got_q.size() < exp_q.size(); t++) step();
        ntot++; if (got_q.size() != exp_q.size() || exp_q.size() == 0)
            $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else npass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            ntot++; if (got_q[i] !== exp_q[i]) $display("FAIL rnd_data i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else npass++;
        end
    endtask

    task automatic test_reset_midstream();
        clear_sb();
        if2.rsp_ready = 1'b1;
        drive(1'b1, 4'hF, 9, 32'hDEAD_BEEF); step();
        if2.rsp_ready = 1'b0;
        drive(1'b1, 4'h0, 1, 32'h0); step();
        drive(1'b1, 4'h0, 2, 32'h0); step();
        drive(1'b0, 4'h0, 0, 32'h0);
        ntot++; if (n_rd != 2) $display("FAIL mid_inflight got=%0d exp=2", n_rd); else npass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ntot++; if (if2.rsp_valid !== 1'b0 || if2.idle !== 1'b1 || if2.req_ready !== 1'b0)
            $display("FAIL mid_rst valid=%b idle=%b ready=%b exp=0/1/0", if2.rsp_valid, if2.idle, if2.req_ready); else npass++;
        rst = 1'b0;
        outst = 0;
        clear_sb();
        #1;
        ntot++; if (if2.req_ready !== 1'b1 || if2.idle !== 1'b1)
            $display("FAIL mid_rel ready=%b idle=%b exp=1/1", if2.req_ready, if2.idle); else npass++;
        @(negedge clk);
        ntot++; if (if2.rsp_valid !== 1'b0) $display("FAIL mid_flushed got=%b exp=0", if2.rsp_valid); else npass++;
        if2.rsp_ready = 1'b1;
        drive(1'b1, 4'h0, 9, 32'h0); step();
        drive(1'b0, 4'h0, 0, 32'h0);
        for (int t = 0; t < 20 && got_q.size() < 1; t++) step();
        ntot++; if (got_q.size() != 1) $display("FAIL mid_count got=%0d exp=1", got_q.size());
        else if (got_q[0] !== 32'hDEAD_BEEF || got_q[0] !== exp_q[0]) $display("FAIL mid_data got=%h exp=DEADBEEF", got_q[0]);
        else npass++;
    endtask

    task automatic test_latency1();
        int k;
        bit seen;
        if1.rsp_ready = 1'b0;
        if1.req_valid = 1'b1; if1.req_we = 4'hF; if1.req_addr = 9'd7; if1.req_wdata = 32'h0BAD_F00D;
        ntot++; if (if1.req_ready !== 1'b1) $display("FAIL l1_ready got=%b exp=1", if1.req_ready); else npass++;
        @(posedge clk); @(negedge clk);
        if1.req_we = 4'h0;
        @(posedge clk); @(negedge clk);
        if1.req_valid = 1'b0;
        k = 1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            ntot++; if (if1.bram_regce !== 1'b0) $display("FAIL l1_regce t=%0d got=%b exp=0", t, if1.bram_regce); else npass++;
            if (if1.rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk); @(negedge clk);
                k++;
            end
        end
        ntot++; if (!seen || k != 2) $display("FAIL l1_latency got=%0d seen=%b exp=2", k, seen); else npass++;
        ntot++; if (if1.rsp_rdata !== 32'h0BAD_F00D) $display("FAIL l1_data got=%h exp=0BADF00D", if1.rsp_rdata); else npass++;
        if1.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        ntot++; if (if1.rsp_valid !== 1'b0 || if1.idle !== 1'b1)
            $display("FAIL l1_drain valid=%b idle=%b exp=0/1", if1.rsp_valid, if1.idle); else npass++;
    endtask

    initial begin
        npass = 0; ntot = 0; cyc = 0; outst = 0; n_rd = 0;
        for (int a = 0; a < 512; a++) model_mem[a] = 32'h0;
        rst = 1'b1;
        drive(1'b0, 4'h0, 0, 32'h0);
        if2.rsp_ready = 1'b0;
        if1.req_valid = 1'b0; if1.req_we = 4'h0; if1.req_addr = 9'd0; if1.req_wdata = 32'h0;
        if1.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_streaming();
        test_byte_enable();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_midstream();
        test_latency1();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
